fifo_read_ctrl: RTL and testbench

- Read-side controller for the dual-clock FIFO; the reader counterpart to the write-port storage block.
- Owns the read pointer and the EMPTY flag, and synchronises the writer's Gray pointer into the read domain.
- Drives the storage array's read address and EMPTY input.
- Presents words through a registered first-word-fall-through output stage with a valid/ready handshake.

---
 rtl/fifo_read_ctrl.sv | 110 +++++++++++
 tb/tb_fifo_read_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the dual-clock FIFO: write-pointer sync, read pointer, EMPTY, FWFT output stage.
// Optional macro FIFO_RD_LEVEL_EN adds the R_LEVEL occupancy output.
module fifo_read_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 5
) (
  input  logic                 RCLK,
  input  logic                 RRST_N,
  input  logic [PTR_WIDTH-1:0] W_PTR_GRAY,
  input  logic [WIDTH-1:0]     R_DO,
  output logic [PTR_WIDTH-1:0] R_PTR,
  output logic [PTR_WIDTH-1:0] R_PTR_GRAY,
  output logic                 EMPTY,
  output logic [WIDTH-1:0]     R_DATA,
  output logic                 R_VALID,
  input  logic                 R_READY
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_WIDTH-1:0] R_LEVEL
`endif
);

  logic [PTR_WIDTH-1:0] r_wq1;
  logic [PTR_WIDTH-1:0] r_wq2;
  logic [PTR_WIDTH-1:0] r_rbin;
  logic [PTR_WIDTH-1:0] r_rgray;
  logic                 r_empty;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;

  logic                 w_fetch;
  logic                 w_rinc;
  logic [PTR_WIDTH-1:0] w_rbin_next;
  logic [PTR_WIDTH-1:0] w_rgray_next;

  // Two-flop synchroniser; the only consumer of the writer's pointer.
  always_ff @(posedge RCLK or negedge RRST_N) begin
    if (!RRST_N) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= W_PTR_GRAY;
      r_wq2 <= r_wq1;
    end
  end

  assign w_fetch      = !r_valid | R_READY;
  assign w_rinc       = w_fetch & !r_empty;
  assign w_rbin_next  = r_rbin + {{(PTR_WIDTH-1){1'b0}}, w_rinc};
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  always_ff @(posedge RCLK or negedge RRST_N) begin
    if (!RRST_N) begin
      r_rbin  <= '0;
      r_rgray <= '0;
      r_empty <= 1'b1;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
      r_empty <= (w_rgray_next == r_wq2);
    end
  end

  // Output register refills whenever it is free or being drained this edge.
  always_ff @(posedge RCLK or negedge RRST_N) begin
    if (!RRST_N) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_rinc) begin
      r_data  <= R_DO;
      r_valid <= 1'b1;
    end else if (R_READY) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_WIDTH-1:0] r_level;
  logic [PTR_WIDTH-1:0] w_wbin_sync;

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_wbin_sync = gray2bin(r_wq2);

  // Occupancy excludes the word already sitting in the output register.
  always_ff @(posedge RCLK or negedge RRST_N) begin
    if (!RRST_N) begin
      r_level <= '0;
    end else begin
      r_level <= w_wbin_sync - w_rbin_next;
    end
  end

  assign R_LEVEL = r_level;
`endif

  assign R_PTR      = r_rbin;
  assign R_PTR_GRAY = r_rgray;
  assign EMPTY      = r_empty;
  assign R_DATA     = r_data;
  assign R_VALID    = r_valid;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl; define FIFO_RD_LEVEL_EN to also exercise R_LEVEL.
module tb_fifo_read_ctrl;
  localparam int WIDTH = 8;
  localparam int PW    = 5;

  logic          RCLK = 1'b0;
  logic          RRST_N;
  logic [PW-1:0] W_PTR_GRAY;
  logic [WIDTH-1:0] R_DO;
  logic [PW-1:0] R_PTR;
  logic [PW-1:0] R_PTR_GRAY;
  logic          EMPTY;
  logic [WIDTH-1:0] R_DATA;
  logic          R_VALID;
  logic          R_READY;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] R_LEVEL;
`endif

  logic [WIDTH-1:0] mem [16];
  logic [PW-1:0]    wbin;
  logic [WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;

  fifo_read_ctrl #(.WIDTH(WIDTH), .PTR_WIDTH(PW)) dut (
    .RCLK(RCLK), .RRST_N(RRST_N), .W_PTR_GRAY(W_PTR_GRAY), .R_DO(R_DO),
    .R_PTR(R_PTR), .R_PTR_GRAY(R_PTR_GRAY), .EMPTY(EMPTY), .R_DATA(R_DATA),
    .R_VALID(R_VALID), .R_READY(R_READY)
`ifdef FIFO_RD_LEVEL_EN
    , .R_LEVEL(R_LEVEL)
`endif
  );

  always #5 RCLK = ~RCLK;
  assign R_DO = mem[R_PTR[3:0]];

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: a transfer is due on the next edge whenever valid & ready.
  always @(negedge RCLK) begin
    if (RRST_N === 1'b1 && R_VALID === 1'b1 && R_READY === 1'b1) begin
      n_checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got %0h expected no word", R_DATA);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (R_DATA !== e) begin
          n_errors++;
          $display("FAIL sb_data: got %0h expected %0h", R_DATA, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge RCLK);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 1'b1;
    W_PTR_GRAY = gray(wbin);
  endtask

  task automatic do_reset();
    RRST_N = 1'b0;
    R_READY = 1'b0;
    wbin = '0;
    W_PTR_GRAY = '0;
    exp_q.delete();
    repeat (2) step();
    RRST_N = 1'b1;
    pop_cnt = 0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (R_VALID !== 1'b1 && n < max) begin
      step();
      n++;
    end
    if (R_VALID !== 1'b1) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Idle after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_flags", {EMPTY, R_VALID}, 2'b10);
      chk("idle_ptrs", {R_PTR, R_PTR_GRAY}, 10'd0);
    end

    // Single word latency, held under backpressure
    do_reset();
    write_word(8'hA5);
    step(); chk("lat_k_empty", EMPTY, 1);
    step(); chk("lat_k1_empty", EMPTY, 1);
    step(); chk("lat_k2_empty", EMPTY, 0); chk("lat_k2_valid", R_VALID, 0);
    step();
    chk("lat_k3_valid", R_VALID, 1); chk("lat_k3_data", R_DATA, 8'hA5);
    chk("lat_k3_ptr", R_PTR, 1); chk("lat_k3_empty", EMPTY, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", R_VALID, 1); chk("hold_data", R_DATA, 8'hA5);
    end
    R_READY = 1'b1;
    step(); chk("drain1_valid", R_VALID, 0);
    chk("drain1_pops", pop_cnt, 1);

    // Four words streaming at full rate
    do_reset();
    R_READY = 1'b1;
    for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i));
    chk("w4_gray", W_PTR_GRAY, 5'h06);
    wait_valid("stream", 8);
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", R_VALID, 1);
      chk("stream_ptr", R_PTR, i + 1);
      chk("stream_data", R_DATA, 8'h10 + i);
      step();
    end
    chk("stream_end", {R_VALID, EMPTY}, 2'b01);
    chk("stream_pops", pop_cnt, 4);

    // Backpressure pattern 1,0,0,1,1
    do_reset();
    write_word(8'h31); write_word(8'h32); write_word(8'h33);
    wait_valid("bp", 8);
    step();
    chk("bp_hold0", R_DATA, 8'h31);
    R_READY = 1'b1; step();
    R_READY = 1'b0; step();
    chk("bp_hold1_a", {R_VALID, R_DATA}, {1'b1, 8'h32});
    step();
    chk("bp_hold1_b", {R_VALID, R_DATA}, {1'b1, 8'h32});
    R_READY = 1'b1; step(); step(); step();
    chk("bp_pops", pop_cnt, 3);
    chk("bp_q_empty", exp_q.size(), 0);
    chk("bp_end", {R_VALID, EMPTY}, 2'b01);

    // Pointer wrap 31 -> 0
    do_reset();
    R_READY = 1'b1;
    for (int i = 0; i < 31; i++) begin
      write_word(8'(i));
      step();
    end
    begin
      int n = 0;
      while (!(R_PTR == 5'd31 && R_VALID === 1'b0) && n < 20) begin step(); n++; end
    end
    chk("wrap_pre_ptr", R_PTR, 31);
    chk("wrap_pre_gray", R_PTR_GRAY, 5'h10);
    chk("wrap_pre_empty", EMPTY, 1);
    write_word(8'hEE);
    chk("wrap_wgray", W_PTR_GRAY, 0);
    begin
      int n = 0;
      while (R_PTR == 5'd31 && n < 10) begin step(); n++; end
    end
    chk("wrap_ptr", R_PTR, 0);
    chk("wrap_gray", R_PTR_GRAY, 0);
    chk("wrap_empty", EMPTY, 1);
    chk("wrap_valid_data", {R_VALID, R_DATA}, {1'b1, 8'hEE});
    step();

`ifdef FIFO_RD_LEVEL_EN
    do_reset();
    chk("lvl_reset", R_LEVEL, 0);
    for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i));
    chk("lvl_wgray", W_PTR_GRAY, 5'h18);
    step(); step(); step();
    chk("lvl_full", R_LEVEL, 16);
    step();
    chk("lvl_after_fetch", R_LEVEL, 15);
    chk("lvl_valid", {R_VALID, R_DATA}, {1'b1, 8'h40});
`else
    do_reset();
    for (int i = 0; i < 6; i++) write_word(8'h40 + 8'(i));
    wait_valid("mid", 8);
`endif

    // Asynchronous reset mid-stream
    #2 RRST_N = 1'b0;
    #1;
    chk("arst_flags", {EMPTY, R_VALID}, 2'b10);
    chk("arst_ptrs", {R_PTR, R_PTR_GRAY}, 10'd0);
    chk("arst_data", R_DATA, 0);
`ifdef FIFO_RD_LEVEL_EN
    chk("arst_level", R_LEVEL, 0);
`endif
    exp_q.delete();
    W_PTR_GRAY = '0;
    wbin = '0;
    step();
    RRST_N = 1'b1;
    step(); step(); step(); step();
    chk("post_rst_idle", {EMPTY, R_VALID}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
